// File: rtl/switch_nport.sv
// NUM_PORTS-way address-decoding switch: one valid/ready input stream fans out to per-port FWFT FIFOs.
// One cycle from accept to out_valid; input stalls when the selected port's FIFO is full, with no bypass.

module switch_nport_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full     = (r_level == LW'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_level    = r_level;
  assign o_head_dat = r_mem[r_rptr];
  // Push is judged against the pre-edge level, so a full FIFO refuses even when it pops this cycle.
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_push_dat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

module switch_nport #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [ADDR_WIDTH-1:0]                         in_addr,
  input  logic [DATA_WIDTH-1:0]                         in_data,
  output logic [NUM_PORTS-1:0]                          out_valid,
  input  logic [NUM_PORTS-1:0]                          out_ready,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0]               out_addr,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]               out_data,
  output logic [NUM_PORTS*($clog2(FIFO_DEPTH)+1)-1:0]   out_level
);
  localparam int SEL_W  = $clog2(NUM_PORTS);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WORD_W = ADDR_WIDTH + DATA_WIDTH;

  logic [SEL_W-1:0]     w_sel;
  logic [NUM_PORTS-1:0] w_full;
  logic [NUM_PORTS-1:0] w_push;
  logic                 r_live;

  // Holds in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  assign w_sel    = in_addr[ADDR_WIDTH-1 -: SEL_W];
  assign in_ready = r_live && !w_full[w_sel];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [WORD_W-1:0] w_head;
    logic              w_empty;

    assign w_push[p] = in_valid && r_live && (w_sel == SEL_W'(p));

    switch_nport_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .i_push     (w_push[p]),
      .i_push_dat ({in_addr, in_data}),
      .i_pop      (out_ready[p]),
      .o_head_dat (w_head),
      .o_full     (w_full[p]),
      .o_empty    (w_empty),
      .o_level    (out_level[p*LVL_W +: LVL_W])
    );

    assign out_valid[p]                          = !w_empty;
    assign out_addr[p*ADDR_WIDTH +: ADDR_WIDTH]  = w_empty ? '0 : w_head[WORD_W-1 -: ADDR_WIDTH];
    assign out_data[p*DATA_WIDTH +: DATA_WIDTH]  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  end
endmodule

// File: tb/tb_switch_nport.sv
// Bench for switch_nport: directed plan steps then random traffic, every cycle compared with per-port queues.
module tb_switch_nport;
  localparam int NP = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_addr;
  logic [15:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_addr;
  logic [63:0] out_data;
  logic [11:0] out_level;

  int checks = 0;
  int errors = 0;
  logic [23:0] q [NP][$];
  bit live = 1'b0;
  bit acc = 1'b0;

  switch_nport dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_level (out_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with inputs driven: checks outputs, then models the next rising edge.
  task automatic step();
    int  sel;
    bit  exp_rdy;
    bit  push;
    bit  pop [NP];
    logic [7:0]  ea;
    logic [15:0] ed;
    #1;
    sel     = int'(in_addr[7:6]);
    exp_rdy = live && (q[sel].size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    for (int p = 0; p < NP; p++) begin
      ea = (q[p].size() != 0) ? q[p][0][23:16] : 8'h00;
      ed = (q[p].size() != 0) ? q[p][0][15:0]  : 16'h0000;
      chk($sformatf("out_valid[%0d]", p), 32'(out_valid[p]), 32'(q[p].size() != 0));
      chk($sformatf("out_addr[%0d]", p),  32'(out_addr[p*8 +: 8]), 32'(ea));
      chk($sformatf("out_data[%0d]", p),  32'(out_data[p*16 +: 16]), 32'(ed));
      chk($sformatf("out_level[%0d]", p), 32'(out_level[p*3 +: 3]), 32'(q[p].size()));
      pop[p] = out_ready[p] && (q[p].size() != 0);
    end
    push = in_valid && exp_rdy;
    @(posedge clk);
    if (rstn === 1'b1) begin
      for (int p = 0; p < NP; p++) begin
        if (pop[p]) void'(q[p].pop_front());
      end
      if (push) q[sel].push_back({in_addr, in_data});
    end
    live = (rstn === 1'b1);
    acc  = push;
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 4'hF;
    for (int i = 0; i < DEPTH + 1; i++) step();
    out_ready = 4'h0;
  endtask

  initial begin
    int n;
    int cyc;
    rstn      = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 8'h10;
    in_data   = 16'h1234;
    out_ready = 4'h0;
    #1 rstn = 1'b0;
    @(negedge clk);

    // Reset held with in_valid high
    step();
    step();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_level", 32'(out_level), 32'd0);
    in_valid = 1'b0;
    rstn = 1'b1;
    step();
    step();

    // Routing to all four ports
    in_valid = 1'b1;
    in_addr = 8'h10; in_data = 16'hAAAA; step();
    in_addr = 8'h50; in_data = 16'hBBBB; step();
    in_addr = 8'h90; in_data = 16'hCCCC; step();
    in_addr = 8'hD0; in_data = 16'hDDDD; step();
    in_valid = 1'b0;
    #1;
    chk("route_level", 32'(out_level), 32'h249);
    chk("route_data", out_data[63:32], 32'hDDDDCCCC);
    chk("route_addr", out_addr, 32'hD0905010);
    step();
    drain();

    // Port 1 fills, then another port is still accepted
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_addr = 8'h40 + 8'(i);
      in_data = 16'h1000 + 16'(i);
      step();
    end
    #1;
    chk("full_level1", 32'(out_level[5:3]), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_addr = 8'h05; in_data = 16'h0505;
    #1;
    chk("other_port_ready", 32'(in_ready), 32'd1);
    step();
    drain();

    // Simultaneous push and pop on port 2
    in_valid = 1'b1;
    in_addr = 8'h80; in_data = 16'h2000; step();
    in_addr = 8'h81; in_data = 16'h2001; step();
    out_ready = 4'b0100;
    for (int i = 2; i < 10; i++) begin
      in_addr = 8'h80 + 8'(i);
      in_data = 16'h2000 + 16'(i);
      step();
      chk("pushpop_level2", 32'(out_level[8:6]), 32'd2);
    end
    drain();

    // Twelve words through port 3 with toggling ready
    in_valid = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 12 && cyc < 200) begin
      in_addr   = 8'hC0 + 8'(n);
      in_data   = 16'h3000 + 16'(n);
      out_ready = {cyc[0] == 1'b0, 3'b000};
      step();
      chk("wrap_level_max", 32'(out_level[11:9] <= 3'd4), 32'd1);
      if (acc) n++;
      cyc++;
    end
    chk("wrap_all_sent", n, 12);
    drain();

    // Asynchronous reset with words buffered on port 0
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_addr = 8'h08 + 8'(i);
      in_data = 16'h0800 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("arst_valid0", 32'(out_valid[0]), 32'd0);
    chk("arst_level0", 32'(out_level[2:0]), 32'd0);
    for (int p = 0; p < NP; p++) q[p].delete();
    live = 1'b0;
    #1 rstn = 1'b1;
    step();
    out_ready = 4'hF;
    step();
    step();

    // Random traffic, holding a stalled word stable
    for (int c = 0; c < 600; c++) begin
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_addr  = 8'($urandom);
        in_data  = 16'($urandom);
      end
      out_ready = 4'($urandom);
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
